// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter/sequencer sharing one ALU among NREQ requesters
//
// Purpose: accepts level requests (instr, op1, op2) from NREQ requesters, picks a winner
// round-robin, issues the operation to the ALU, waits for instr_exec (bounded by a
// TIMEOUT watchdog) and returns the result with a one-cycle done pulse.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-low reset
//   req/req_instr/req_op1/req_op2   per-requester request and packed operand buses
//   gnt, done             one-hot pulses: request accepted / response valid
//   rsp_result, rsp_err   response data and timeout flag, held until the next response
//   busy                  high whenever an operation is in progress
//   alu_enable/alu_instr/alu_op1/alu_op2   issue port towards the ALU
//   alu_instr_exec/alu_result              completion port from the ALU

module alu_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int INSTR_W = 32,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*INSTR_W-1:0] req_instr,
    input  logic [NREQ*XLEN-1:0]    req_op1,
    input  logic [NREQ*XLEN-1:0]    req_op2,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [XLEN-1:0]         rsp_result,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    alu_enable,
    output logic [INSTR_W-1:0]      alu_instr,
    output logic [XLEN-1:0]         alu_op1,
    output logic [XLEN-1:0]         alu_op2,
    input  logic                    alu_instr_exec,
    input  logic [XLEN-1:0]         alu_result
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [XLEN-1:0]    rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               alu_enable_q, alu_enable_d;
    logic [INSTR_W-1:0] alu_instr_q, alu_instr_d;
    logic [XLEN-1:0]    alu_op1_q, alu_op1_d;
    logic [XLEN-1:0]    alu_op2_q, alu_op2_d;

    // Round-robin pick: first set request bit scanning ptr, ptr+1, ... wrapping at NREQ.
    logic             arb_found;
    logic [PTR_W-1:0] arb_sel;
    int               arb_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!arb_found && req[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = PTR_W'(arb_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + CNT_W'(1);
        gnt_d        = '0;
        done_d       = '0;
        alu_enable_d = 1'b0;
        alu_instr_d  = alu_instr_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    alu_instr_d    = req_instr[int'(arb_sel)*INSTR_W +: INSTR_W];
                    alu_op1_d      = req_op1[int'(arb_sel)*XLEN +: XLEN];
                    alu_op2_d      = req_op2[int'(arb_sel)*XLEN +: XLEN];
                    ptr_d          = (arb_sel == PTR_LAST) ? '0 : arb_sel + PTR_W'(1);
                    win_d          = arb_sel;
                    cnt_d          = '0;
                    gnt_d[arb_sel] = 1'b1;
                    alu_enable_d   = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            // ISSUE and WAIT share completion logic; the counter starts in ISSUE so that
            // a missing exec completes exactly TIMEOUT cycles after the grant.
            S_ISSUE, S_WAIT: begin
                if (alu_instr_exec) begin
                    rsp_result_d  = alu_result;
                    rsp_err_d     = 1'b0;
                    done_d[win_q] = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_inc;
                    end
                    if (cnt_q == CNT_MAX || cnt_inc == CNT_MAX) begin
                        rsp_result_d  = '0;
                        rsp_err_d     = 1'b1;
                        done_d[win_q] = 1'b1;
                        state_d       = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            alu_enable_q <= 1'b0;
            alu_instr_q  <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            alu_enable_q <= alu_enable_d;
            alu_instr_q  <= alu_instr_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign alu_enable = alu_enable_q;
    assign alu_instr  = alu_instr_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - self-checking bench for alu_req_arbiter

module tb_alu_req_arbiter;

    localparam int NREQ    = 4;
    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*INSTR_W-1:0] req_instr;
    logic [NREQ*XLEN-1:0]    req_op1;
    logic [NREQ*XLEN-1:0]    req_op2;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic [XLEN-1:0]         rsp_result;
    logic                    rsp_err;
    logic                    busy;
    logic                    alu_enable;
    logic [INSTR_W-1:0]      alu_instr;
    logic [XLEN-1:0]         alu_op1;
    logic [XLEN-1:0]         alu_op2;
    logic                    alu_instr_exec;
    logic [XLEN-1:0]         alu_result;

    alu_req_arbiter #(
        .NREQ(NREQ), .INSTR_W(INSTR_W), .XLEN(XLEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_instr(req_instr), .req_op1(req_op1),
        .req_op2(req_op2), .gnt(gnt), .done(done), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy), .alu_enable(alu_enable), .alu_instr(alu_instr),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instr_exec(alu_instr_exec),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int m_ptr    = 0;
    int last_gnt = -100;

    logic [INSTR_W-1:0] ins_a [NREQ];
    logic [XLEN-1:0]    op1_a [NREQ];
    logic [XLEN-1:0]    op2_a [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [XLEN-1:0] alu_fn(logic [INSTR_W-1:0] ins, logic [XLEN-1:0] a,
                                               logic [XLEN-1:0] b);
        case (ins[2:0])
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic int model_winner(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_instr[i*INSTR_W +: INSTR_W] = ins_a[i];
            req_op1[i*XLEN +: XLEN]         = op1_a[i];
            req_op2[i*XLEN +: XLEN]         = op2_a[i];
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            ins_a[i] = $urandom;
            op1_a[i] = $urandom;
            op2_a[i] = $urandom;
        end
        pack_ops();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        alu_instr_exec = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_ptr = 0;
        last_gnt = -100;
    endtask

    // Waits for the next grant, checks it against the round-robin model, plays an ALU that
    // answers lat cycles after the enable cycle, and checks the response. w_act is the
    // requester actually granted by the DUT (-1 if none).
    task automatic serve(input int lat, input bit clr, output int w_act);
        int              waitc;
        int              exp_w;
        int              exp_n;
        logic            exp_err;
        logic [XLEN-1:0] exp_res;
        logic [NREQ-1:0] rp;
        logic [NREQ-1:0] exp_oh;
        waitc = 0;
        w_act = -1;
        rp = req;
        tick();
        while (gnt === '0 && waitc < 20) begin
            rp = req;
            tick();
            waitc++;
        end
        exp_w  = model_winner(rp, m_ptr);
        exp_oh = '0;
        if (exp_w >= 0) exp_oh[exp_w] = 1'b1;
        n_cmp++;
        if (gnt !== exp_oh) begin
            n_bad++;
            $display("FAIL gnt_winner: got %b expected %b", gnt, exp_oh);
        end
        for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) w_act = i;
        if (exp_w < 0 || gnt === '0) return;
        n_cmp++;
        if ({alu_enable, busy, done} !== {1'b1, 1'b1, {NREQ{1'b0}}}) begin
            n_bad++;
            $display("FAIL issue_flags: got en=%b busy=%b done=%b expected en=1 busy=1 done=0",
                     alu_enable, busy, done);
        end
        n_cmp++;
        if ({alu_instr, alu_op1, alu_op2} !== {ins_a[exp_w], op1_a[exp_w], op2_a[exp_w]}) begin
            n_bad++;
            $display("FAIL issue_operands: got %h/%h/%h expected %h/%h/%h", alu_instr, alu_op1,
                     alu_op2, ins_a[exp_w], op1_a[exp_w], op2_a[exp_w]);
        end
        if (last_gnt >= 0) begin
            n_cmp++;
            if (cyc - last_gnt < 3) begin
                n_bad++;
                $display("FAIL gnt_spacing: got %0d cycles expected >=3", cyc - last_gnt);
            end
        end
        last_gnt = cyc;
        m_ptr = (exp_w + 1) % NREQ;
        if (clr) req[exp_w] = 1'b0;
        exp_n   = (lat <= TIMEOUT - 1) ? lat + 1 : TIMEOUT;
        exp_err = (lat > TIMEOUT - 1);
        exp_res = exp_err ? '0 : alu_fn(ins_a[exp_w], op1_a[exp_w], op2_a[exp_w]);
        for (int j = 0; j < exp_n; j++) begin
            alu_instr_exec = (j == lat);
            alu_result = (j == lat) ? alu_fn(alu_instr, alu_op1, alu_op2) : XLEN'($urandom);
            tick();
            if (j + 1 < exp_n) begin
                n_cmp++;
                if ({done, gnt, alu_enable} !== '0) begin
                    n_bad++;
                    $display("FAIL quiet_wait: got done=%b gnt=%b en=%b at cycle %0d expected 0",
                             done, gnt, alu_enable, j + 1);
                end
            end
        end
        alu_instr_exec = 1'b0;
        n_cmp++;
        if ({done, gnt} !== {exp_oh, {NREQ{1'b0}}}) begin
            n_bad++;
            $display("FAIL done_pulse: got done=%b gnt=%b expected done=%b gnt=0", done, gnt, exp_oh);
        end
        n_cmp++;
        if ({rsp_result, rsp_err} !== {exp_res, exp_err}) begin
            n_bad++;
            $display("FAIL response: got %h err=%b expected %h err=%b", rsp_result, rsp_err,
                     exp_res, exp_err);
        end
    endtask

    task automatic test_reset();
        int w;
        int waitc;
        do_reset();
        n_cmp++;
        if ({gnt, done, rsp_result, rsp_err, busy, alu_enable, alu_instr, alu_op1, alu_op2} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: outputs not all zero (busy=%b en=%b)", busy, alu_enable);
        end
        randomize_ops();
        req = 4'b0001;
        waitc = 0;
        tick();
        while (gnt === '0 && waitc < 5) begin
            tick();
            waitc++;
        end
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_pre_gnt: got %b expected 0001", gnt);
        end
        req = '0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({gnt, done, rsp_result, rsp_err, busy, alu_enable, alu_instr, alu_op1, alu_op2} !== '0) begin
                n_bad++;
                $display("FAIL reset_midwait: got busy=%b done=%b op1=%h expected all zero",
                         busy, done, alu_op1);
            end
        end
        rst = 1'b1;
        alu_instr_exec = 1'b1;
        alu_result = 32'hdead_beef;
        tick();
        alu_instr_exec = 1'b0;
        tick();
        n_cmp++;
        if ({done, busy, rsp_result} !== '0) begin
            n_bad++;
            $display("FAIL reset_late_exec: got done=%b busy=%b res=%h expected 0", done, busy,
                     rsp_result);
        end
        m_ptr = 0;
        last_gnt = -100;
        req = 4'b1111;
        serve(2, 1'b1, w);
        n_cmp++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL reset_first_gnt: got %0d expected 0", w);
        end
        req = '0;
    endtask

    task automatic test_single_op();
        int w;
        randomize_ops();
        ins_a[2] = 32'd0;
        op1_a[2] = 32'd5;
        op2_a[2] = 32'd7;
        pack_ops();
        req = 4'b0100;
        serve(3, 1'b1, w);
        n_cmp++;
        if (rsp_result !== 32'd12 || w != 2) begin
            n_bad++;
            $display("FAIL single_op: got w=%0d res=%0d expected w=2 res=12", w, rsp_result);
        end
        tick();
        n_cmp++;
        if ({done, busy} !== '0) begin
            n_bad++;
            $display("FAIL single_done_once: got done=%b busy=%b expected 0", done, busy);
        end
    endtask

    task automatic test_fairness();
        int w;
        do_reset();
        randomize_ops();
        req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            serve($urandom_range(0, 4), 1'b0, w);
            n_cmp++;
            if (w != n % NREQ) begin
                n_bad++;
                $display("FAIL fair_order[%0d]: got %0d expected %0d", n, w, n % NREQ);
            end
            if (w >= 0) begin
                req[w] = 1'b0;
                tick();
                req[w] = 1'b1;
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        int w;
        randomize_ops();
        req = 4'b1 << $urandom_range(0, NREQ - 1);
        serve(1000, 1'b1, w);
        randomize_ops();
        req = NREQ'($urandom_range(1, 15));
        serve($urandom_range(0, 5), 1'b1, w);
        req = '0;
    endtask

    task automatic test_zero_latency();
        int w;
        for (int n = 0; n < 3; n++) begin
            randomize_ops();
            req = NREQ'($urandom_range(1, 15));
            serve(0, 1'b1, w);
        end
        req = '0;
    endtask

    task automatic test_boundary();
        int w;
        randomize_ops();
        req = NREQ'($urandom_range(1, 15));
        serve(TIMEOUT - 1, 1'b1, w);
        randomize_ops();
        req = NREQ'($urandom_range(1, 15));
        serve(TIMEOUT - 2, 1'b1, w);
        randomize_ops();
        req = NREQ'($urandom_range(1, 15));
        serve(TIMEOUT, 1'b1, w);
        req = '0;
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 25; n++) begin
            randomize_ops();
            req = NREQ'($urandom_range(1, 15));
            serve($urandom_range(0, TIMEOUT + 3), 1'($urandom_range(0, 1)), w);
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        req_instr = '0;
        req_op1 = '0;
        req_op2 = '0;
        alu_instr_exec = 1'b0;
        alu_result = '0;
        test_reset();
        test_single_op();
        test_fairness();
        test_timeout();
        test_zero_latency();
        test_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
